spi_reg_ctrl: RTL and testbench

//   SPI slave register controller that configures the PWM peripheral. Receives 16-bit

---
 rtl/spi_reg_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/spi_reg_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared frame layout, register map and FSM state type for the SPI register controller.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL,
        COMMIT
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection on the synced level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave that writes 16-bit frames into the five PWM configuration registers.
// Define SPI_READBACK_EN to enable register readback on cipo for frames with bit15=0.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse
);

    // state  | meaning
    // IDLE   | waiting for nCS fall
    // SHIFT  | capturing COPI on each SCLK rise
    // FULL   | 16 bits held, extra SCLK ignored, waiting for nCS rise
    // COMMIT | single-cycle write decision

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_sync;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d, cnt_next;
    logic [FRAME_BITS-1:0]   shift_q, shift_d, shift_next;
    logic [DATA_W-1:0]       out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [DATA_W-1:0]       pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
    logic [DATA_W-1:0]       duty_q, duty_d;
    logic                    wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]       frame_addr;
    logic [DATA_W-1:0]       frame_data;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < 8'(NUM_REGS);
    endfunction

    assign shift_next = {shift_q[FRAME_BITS-2:0], copi_lvl};
    assign cnt_next   = cnt_q + 5'd1;
    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_q[DATA_MSB:DATA_LSB];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        out_lo_d   = out_lo_q;
        out_hi_d   = out_hi_q;
        pwm_lo_d   = pwm_lo_q;
        pwm_hi_d   = pwm_hi_q;
        duty_d     = duty_q;
        wr_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_next;
                    if (cnt_next == 5'(FRAME_BITS)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (shift_q[RW_BIT] && addr_ok(frame_addr)) begin
                    wr_pulse_d = 1'b1;
                    case (frame_addr)
                        ADDR_EN_OUT_LO: out_lo_d = frame_data;
                        ADDR_EN_OUT_HI: out_hi_d = frame_data;
                        ADDR_EN_PWM_LO: pwm_lo_d = frame_data;
                        ADDR_EN_PWM_HI: pwm_hi_d = frame_data;
                        ADDR_DUTY:      duty_d   = frame_data;
                        default:        wr_pulse_d = 1'b0;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            out_lo_q   <= '0;
            out_hi_q   <= '0;
            pwm_lo_q   <= '0;
            pwm_hi_q   <= '0;
            duty_q     <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            out_lo_q   <= out_lo_d;
            out_hi_q   <= out_hi_d;
            pwm_lo_q   <= pwm_lo_d;
            pwm_hi_q   <= pwm_hi_d;
            duty_q     <= duty_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d, rd_mux;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr;

    // Address is complete after 8 bits, so its fields sit 8 places lower in the shifter.
    assign rd_addr = shift_next[ADDR_MSB-DATA_W:ADDR_LSB-DATA_W];

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_EN_OUT_LO: rd_mux = out_lo_q;
            ADDR_EN_OUT_HI: rd_mux = out_hi_q;
            ADDR_EN_PWM_LO: rd_mux = pwm_lo_q;
            ADDR_EN_PWM_HI: rd_mux = pwm_hi_q;
            ADDR_DUTY:      rd_mux = duty_q;
            default:        rd_mux = '0;
        endcase
    end

    always_comb begin
        rd_shift_d = rd_shift_q;
        rd_valid_d = rd_valid_q;
        if (state_q != SHIFT || ncs_rise) begin
            rd_valid_d = 1'b0;
        end else if (sclk_rise && cnt_next == 5'(FRAME_BITS-DATA_W)) begin
            rd_valid_d = !shift_next[RW_BIT-DATA_W] && addr_ok(rd_addr);
            rd_shift_d = rd_mux;
        end else if (sclk_fall && rd_valid_q && cnt_q > 5'(FRAME_BITS-DATA_W)) begin
            rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_shift_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_shift_q <= rd_shift_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign cipo        = rd_valid_q & rd_shift_q[DATA_W-1];
    assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall, ncs_lvl};
`else
    assign cipo        = 1'b0;
    assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};
`endif

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_pulse        = wr_pulse_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected writes are queued when a frame ends and
// popped when wr_pulse fires; register file and cipo are checked against a bench model.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, copi, ncs;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse;

    spi_reg_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif
    localparam int LATENCY = 4;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         rise_cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mdl [5];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int a);
        case (a)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            4:       return pwm_duty_cycle;
            default: return 8'h00;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (wr_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_pulse", 32'(wr_pulse), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_data", 32'(dut_reg(e.addr)), 32'(e.data));
                chk("wr_latency", 32'(cyc - e.rise_cyc), 32'(LATENCY));
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 5; a++) begin
            chk($sformatf("%s_reg%0d", tag, a), 32'(dut_reg(a)), 32'(mdl[a]));
        end
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        clk_n(8);
    endtask

    // Bits beyond 16 drive COPI high so an overlong frame would corrupt data if kept.
    task automatic send_bits(input logic [15:0] frame, input int first, input int last,
                             input logic [7:0] rd_exp);
        for (int i = first; i < last; i++) begin
            copi = (i < 16) ? frame[15-i] : 1'b1;
            clk_n(8);
            if (i >= 8 && i < 16) chk($sformatf("cipo_bit%0d", i + 1), 32'(cipo), 32'(rd_exp[15-i]));
            else if (i < 8)       chk($sformatf("cipo_bit%0d", i + 1), 32'(cipo), 32'd0);
            sclk = 1'b1;
            clk_n(8);
            sclk = 1'b0;
        end
    endtask

    task automatic raise_cs(input logic [15:0] frame, input bit full);
        copi = 1'b0;
        clk_n(2);
        ncs = 1'b1;
        if (full && frame[15] && frame[14:8] < 7'd5) begin
            wr_t e;
            e.addr     = int'(frame[14:8]);
            e.data     = frame[7:0];
            e.rise_cyc = cyc;
            exp_q.push_back(e);
            mdl[e.addr] = e.data;
        end
    endtask

    task automatic settle(input string tag);
        clk_n(12);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check_regs(tag);
    endtask

    task automatic wr_frame(input string tag, input logic [15:0] frame);
        cs_low();
        send_bits(frame, 0, 16, 8'h00);
        raise_cs(frame, 1'b1);
        settle(tag);
    endtask

    task automatic rd_frame(input string tag, input logic [15:0] frame);
        logic [7:0] rexp;
        int         a;
        a    = int'(frame[14:8]);
        rexp = (READBACK && a < 5) ? mdl[a] : 8'h00;
        cs_low();
        send_bits(frame, 0, 16, rexp);
        raise_cs(frame, 1'b1);
        settle(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        for (int a = 0; a < 5; a++) mdl[a] = 8'h00;
        clk_n(5);
        rst_n = 1'b1;
        clk_n(4);

        check_regs("reset");
        chk("reset_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("reset_cipo", 32'(cipo), 32'd0);

        wr_frame("w_addr0", 16'h80FF);
        wr_frame("w_addr4", 16'h8480);
        wr_frame("w_bad_addr", 16'h8A55);
        wr_frame("w_addr7f", 16'hFF12);

        cs_low();
        send_bits(16'h81AB, 0, 12, 8'h00);
        raise_cs(16'h81AB, 1'b0);
        settle("short_frame");
        wr_frame("w_after_short", 16'h8133);

        cs_low();
        send_bits(16'h8207, 0, 20, 8'h00);
        raise_cs(16'h8207, 1'b1);
        settle("overlong");

        wr_frame("lww_first", 16'h8011);
        wr_frame("lww_second", 16'h8022);

        // nCS blips high for one clk: the fall lands in COMMIT and must be ignored,
        // so the frame clocked in afterwards never starts.
        cs_low();
        send_bits(16'h8344, 0, 16, 8'h00);
        raise_cs(16'h8344, 1'b1);
        clk_n(1);
        ncs = 1'b0;
        clk_n(8);
        send_bits(16'h8255, 0, 16, 8'h00);
        raise_cs(16'h8255, 1'b0);
        settle("fall_in_commit");

        wr_frame("w_addr3", 16'h83C3);
        rd_frame("rd_addr3", 16'h0300);
        rd_frame("rd_addr0", 16'h0000);
        rd_frame("rd_bad_addr", 16'h0A00);

        cs_low();
        send_bits(16'h82AA, 0, 8, 8'h00);
        rst_n = 1'b0;
        clk_n(3);
        for (int a = 0; a < 5; a++) mdl[a] = 8'h00;
        check_regs("in_reset");
        chk("in_reset_wr_pulse", 32'(wr_pulse), 32'd0);
        rst_n = 1'b1;
        clk_n(2);
        send_bits(16'h82AA, 8, 16, 8'h00);
        raise_cs(16'h82AA, 1'b0);
        settle("reset_mid_frame");
        wr_frame("w_after_reset", 16'h82AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
